// File: rtl/serial_tx.sv
// serial_tx: valid/ready serial frame transmitter, LSB-first (start, data, [parity], stop).
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_serial,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_MAX = BW'(DATA_W - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd4;
`ifdef SERIAL_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;
`endif

  logic [2:0]        r_state;
  logic [DATA_W-1:0] r_shift;
  logic [CW-1:0]     r_cnt;
  logic [BW-1:0]     r_bit;
  logic              r_serial;
  logic              r_ready;
  logic              r_busy;
  logic              r_done;
`ifdef SERIAL_TX_PARITY_EN
  logic              r_parity;
`endif

  logic              w_bit_end;
  logic              w_last_bit;
  logic [DATA_W-1:0] w_shift_nxt;

  assign w_bit_end   = (r_cnt == CNT_MAX);
  assign w_last_bit  = (r_bit == BIT_MAX);
  assign w_shift_nxt = r_shift >> 1;

  assign tx_ready  = r_ready;
  assign tx_serial = r_serial;
  assign tx_busy   = r_busy;
  assign tx_done   = r_done;

  // The line register is loaded with the value of the bit being entered, so every
  // output change lands exactly on the bit boundary with no combinational path.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_shift  <= '0;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_serial <= 1'b1;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (tx_valid && r_ready) begin
            r_shift  <= tx_data;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_serial <= 1'b0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= ST_START;
`ifdef SERIAL_TX_PARITY_EN
            r_parity <= ^tx_data;
`endif
          end
        end
        ST_START: begin
          if (w_bit_end) begin
            r_cnt    <= '0;
            r_serial <= r_shift[0];
            r_state  <= ST_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (w_last_bit) begin
`ifdef SERIAL_TX_PARITY_EN
              r_serial <= r_parity;
              r_state  <= ST_PARITY;
`else
              r_serial <= 1'b1;
              r_state  <= ST_STOP;
`endif
            end else begin
              r_bit    <= r_bit + 1'b1;
              r_shift  <= w_shift_nxt;
              r_serial <= w_shift_nxt[0];
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`ifdef SERIAL_TX_PARITY_EN
        ST_PARITY: begin
          if (w_bit_end) begin
            r_cnt    <= '0;
            r_serial <= 1'b1;
            r_state  <= ST_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`endif
        ST_STOP: begin
          // Ready returns in the done cycle so a waiting word starts right after the stop bit.
          if (w_bit_end) begin
            r_cnt    <= '0;
            r_serial <= 1'b1;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_serial <= 1'b1;
          r_ready  <= 1'b1;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// Scoreboard bench for serial_tx: two instances (CLKS_PER_BIT 4 and 1) checked per cycle
// against frames expanded from the accepted words by a bit-list model.
`timescale 1ns/1ps
module tb_serial_tx;

  localparam int DW = 8;
`ifdef SERIAL_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [DW-1:0] d0, d1;
  logic v0, v1;
  logic rdy0, rdy1, ser0, ser1, busy0, busy1, done0, done1;

  wire [1:0] rdy_w  = {rdy1, rdy0};
  wire [1:0] ser_w  = {ser1, ser0};
  wire [1:0] busy_w = {busy1, busy0};
  wire [1:0] done_w = {done1, done0};

  int total = 0;
  int bad   = 0;
  bit expq [2][$];
  int lenq [2][$];
  int cyc [2];
  bit prev_done [2];
  bit acc_in_done;

  always #5 clk = ~clk;

  serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(4)) u_dut4 (
    .clk(clk), .rst(rst), .tx_data(d0), .tx_valid(v0), .tx_ready(rdy0),
    .tx_serial(ser0), .tx_busy(busy0), .tx_done(done0)
  );

  serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(1)) u_dut1 (
    .clk(clk), .rst(rst), .tx_data(d1), .tx_valid(v1), .tx_ready(rdy1),
    .tx_serial(ser1), .tx_busy(busy1), .tx_done(done1)
  );

  function automatic int cpb_of(int idx);
    return (idx == 0) ? 4 : 1;
  endfunction

  task automatic check(string name, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame as a list of line levels, each repeated for one bit time.
  task automatic push_frame(int idx, logic [DW-1:0] d);
    bit bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(d[i]);
    if (PAR != 0) bits.push_back(^d);
    bits.push_back(1'b1);
    foreach (bits[k]) repeat (cpb_of(idx)) expq[idx].push_back(bits[k]);
    lenq[idx].push_back(bits.size() * cpb_of(idx));
  endtask

  task automatic send(int idx, logic [DW-1:0] d);
    int n = 0;
    @(negedge clk);
    if (idx == 0) begin v0 = 1'b1; d0 = d; end
    else          begin v1 = 1'b1; d1 = d; end
    while (!rdy_w[idx]) begin
      n++;
      if (n > 300) begin
        check("accept_timeout", 1, 0);
        return;
      end
      @(negedge clk);
    end
    acc_in_done = done_w[idx];
    push_frame(idx, d);
    @(posedge clk);
    #1;
  endtask

  task automatic drop(int idx);
    @(negedge clk);
    if (idx == 0) v0 = 1'b0;
    else          v1 = 1'b0;
  endtask

  task automatic wait_drain(int idx);
    int n = 0;
    while (lenq[idx].size() != 0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    check("drain_frames", lenq[idx].size(), 0);
    check("drain_bits", expq[idx].size(), 0);
  endtask

  task automatic check_rst_outs(string tag);
    for (int i = 0; i < 2; i++) begin
      check({tag, "_serial"}, int'(ser_w[i]), 1);
      check({tag, "_ready"}, int'(rdy_w[i]), 1);
      check({tag, "_busy"}, int'(busy_w[i]), 0);
      check({tag, "_done"}, int'(done_w[i]), 0);
    end
  endtask

  // Monitor: pops one expected line level per busy cycle, frame length at each done pulse.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (!rst) begin
        cyc[g] = 0;
        prev_done[g] = 1'b0;
      end else begin
        check("ready_vs_busy", int'(rdy_w[g]), int'(!busy_w[g]));
        if (busy_w[g]) begin
          cyc[g]++;
          if (expq[g].size() == 0) check("unexpected_busy", 1, 0);
          else check("line", int'(ser_w[g]), int'(expq[g].pop_front()));
        end else begin
          check("idle_line", int'(ser_w[g]), 1);
        end
        if (done_w[g]) begin
          if (lenq[g].size() == 0) check("spurious_done", 1, 0);
          else check("frame_cycles", cyc[g], lenq[g].pop_front());
          check("done_single", int'(prev_done[g]), 0);
          cyc[g] = 0;
        end
        prev_done[g] = done_w[g];
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    logic [DW-1:0] rd;
    v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0;
    repeat (3) @(negedge clk);
    check_rst_outs("reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_rst_outs("post_reset");

    // Directed frames, parity cases, and the one-cycle-per-bit instance.
    send(0, 8'hA5); drop(0); wait_drain(0);
    send(0, 8'h01); drop(0); wait_drain(0);
    send(1, 8'h5A); drop(1); wait_drain(1);

    // Back-to-back with valid held high.
    send(0, 8'h00); send(0, 8'hFF);
    check("b2b_accept_in_done_4", int'(acc_in_done), 1);
    drop(0); wait_drain(0);
    send(1, 8'h00); send(1, 8'hFF);
    check("b2b_accept_in_done_1", int'(acc_in_done), 1);
    drop(1); wait_drain(1);

    // Data change and valid pulse while busy must not disturb the frame.
    send(0, 8'h81);
    @(negedge clk);
    d0 = 8'h3C; v0 = 1'b1;
    check("ready_while_busy", int'(rdy0), 0);
    @(negedge clk);
    v0 = 1'b0;
    wait_drain(0);
    repeat (4) @(negedge clk);
    check("no_extra_frame", int'(busy0), 0);

    // Asynchronous reset in the middle of a data bit that drives the line low.
    send(0, 8'hC3); drop(0);
    repeat (14) @(posedge clk);
    #3 rst = 1'b0;
    #1 check("midrst_serial", int'(ser0), 1);
    check("midrst_ready", int'(rdy0), 1);
    check("midrst_busy", int'(busy0), 0);
    check("midrst_done", int'(done0), 0);
    repeat (2) @(negedge clk);
    check_rst_outs("midrst_hold");
    expq[0].delete(); lenq[0].delete();
    rst = 1'b1;
    repeat (60) @(negedge clk);
    check("midrst_no_busy", int'(busy0), 0);

    // Randomized words with random gaps, zero gap meaning valid held back-to-back.
    for (int idx = 0; idx < 2; idx++) begin
      for (int i = 0; i < 25; i++) begin
        rd  = DW'($urandom);
        gap = int'($urandom_range(0, 3));
        send(idx, rd);
        if (gap != 0) begin
          drop(idx);
          repeat (gap) @(negedge clk);
        end
      end
      drop(idx);
      wait_drain(idx);
    end

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
- Serial frame transmitter; the sending end of the single-wire serial link whose receive side samples the line with flip-flops.
- Accepts a parallel word through a valid/ready handshake and shifts it out LSB-first.
- Frame format: start bit, data bits, optional parity bit, stop bit.
- Each bit is held for a fixed number of clk cycles. Sits between a local producer (FSM or register file) and the top-level tx pin.

Parameters:
- DATA_W, 8: data bits per frame; must be >= 1.
- CLKS_PER_BIT, 4: clk cycles each bit is held on tx_serial; must be >= 1.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset; asynchronous, active-low.
- tx_data  input  DATA_W  word to send; sampled only at acceptance.
- tx_valid  input  1  producer has a word on tx_data.
- tx_ready  output  1  block can accept a word this cycle.
- tx_serial  output  1  serial line; idles high.
- tx_busy  output  1  frame in progress.
- tx_done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, tx_serial=1, tx_ready=1, tx_busy=0, tx_done=0; shift register and counters cleared. All outputs are registered.
- States: IDLE, START, DATA, PARITY (present only with macro), STOP.
- IDLE: tx_serial=1, tx_ready=1, tx_busy=0.
  - Acceptance = rising edge with tx_valid=1 and tx_ready=1.
  - At acceptance: tx_data is copied to the shift register, state goes to START, tx_ready goes to 0, tx_busy goes to 1.
  - tx_serial=0 from the next cycle.
- START: line=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: line = shift-register bit 0, held CLKS_PER_BIT cycles, then shift right.
  - Bit counter runs 0..DATA_W-1.
  - After bit DATA_W-1 completes: go to PARITY if enabled, else STOP.
- STOP: line=1 for CLKS_PER_BIT cycles, then IDLE.
  - The transition to IDLE sets tx_done=1 for exactly one cycle, together with tx_ready=1 and tx_busy=0.
- Timing and widths:
  - Cycle counter width is $clog2(CLKS_PER_BIT), minimum 1; it wraps to 0 at CLKS_PER_BIT-1.
  - Bit counter width is $clog2(DATA_W), minimum 1.
  - Frame length on the line = (DATA_W+2[+1 parity])*CLKS_PER_BIT cycles.
- Back-to-back: a word offered in the tx_done cycle is accepted. Its start bit begins the next cycle, so there is no idle gap beyond the stop bit.
- Ignored inputs:
  - tx_valid while tx_busy=1 is ignored. The producer must hold tx_valid and tx_data until acceptance.
  - Changes on tx_data after acceptance do not affect the frame in flight.
- Reset mid-frame: the line returns to 1 immediately. The partial frame is discarded; no tx_done is produced.
- CLKS_PER_BIT=1: one bit per cycle, with no lost or duplicated bits.

Optional Feature:
- Macro: SERIAL_TX_PARITY_EN.
- Defined: PARITY state inserted between DATA and STOP. The line carries the even-parity bit (XOR of all DATA_W bits of the accepted word) for CLKS_PER_BIT cycles. Frame length becomes (DATA_W+3)*CLKS_PER_BIT.
- Undefined: no PARITY state and no parity logic; DATA goes directly to STOP.

Test Plan:
1. Reset mid-frame → while rst=0: tx_serial=1, tx_ready=1, tx_busy=0, tx_done=0. With rst asserted asynchronously mid-frame (between clk edges): tx_serial=1 before the next clk edge; no tx_done follows.
2. DATA_W=8, CLKS_PER_BIT=4, send 0xA5, no parity → line sequence per bit 0,1,0,1,0,0,1,0,1,1. Each bit lasts 4 cycles (40 total); tx_done pulses once, 40 cycles after the start bit begins.
3. SERIAL_TX_PARITY_EN defined → 0xA5 gives parity bit 0 and 0x01 gives parity bit 1, each inserted before the stop bit; frame is 44 cycles.
4. Back-to-back 0x00 then 0xFF with tx_valid held high → second start bit begins the cycle after tx_done. Line shows 0,0×8,1,0,1×8,1 with no extra idle.
5. tx_data changed to 0x3C and tx_valid pulsed while busy sending 0x81 → line still shows 0x81. The pulse is not accepted; tx_ready stays 0 until tx_done.
6. CLKS_PER_BIT=1, send 0x5A → ten consecutive cycles 0,0,1,0,1,1,0,1,0,1; tx_done on the 11th cycle.
